// File: rtl/prime_pkg.sv
// ============================================================================
// prime_pkg : shared FSM states, first odd divisor and 6k+-1 step helper
// Revision  : 1.0
// ============================================================================
`default_nettype none

package prime_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CLASSIFY = 3'd1,
      CHECK    = 3'd2,
      WAIT     = 3'd3,
      RESULT   = 3'd4
   } state_t;

   localparam int FIRST_ODD_DIV = 3;

   // Candidate step once past the first odd divisor: phase 0 -> +2, phase 1 -> +4.
   function automatic logic [2:0] div_step(input logic phase);
      return phase ? 3'd4 : 3'd2;
   endfunction

endpackage

`default_nettype wire

// File: rtl/prime_rem_unit.sv
// ============================================================================
// prime_rem_unit : restoring serial remainder, one quotient bit per clock
// Revision       : 1.0
// ============================================================================
`default_nettype none

module prime_rem_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             rem_done,
   output logic [WIDTH-1:0] rem
);

   localparam int CW = $clog2(WIDTH);

   logic             running;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] div_r;

   logic             load;
   logic [WIDTH-1:0] cur_div;
   logic [WIDTH-1:0] cur_rem;
   logic             cur_bit;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   next_rem;

   // The first bit is processed on the start edge so rem_done lands WIDTH cycles later.
   assign load     = start & ~running;
   assign cur_div  = load ? divisor : div_r;
   assign cur_rem  = load ? '0 : rem;
   assign cur_bit  = load ? dividend[WIDTH-1] : shreg[WIDTH-1];
   assign trial    = {cur_rem, cur_bit};
   assign next_rem = (trial >= {1'b0, cur_div}) ? (trial - {1'b0, cur_div}) : trial;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running  <= 1'b0;
         cnt      <= '0;
         shreg    <= '0;
         div_r    <= '0;
         rem      <= '0;
         rem_done <= 1'b0;
      end else begin
         rem_done <= 1'b0;
         if (load) begin
            rem     <= next_rem[WIDTH-1:0];
            shreg   <= {dividend[WIDTH-2:0], 1'b0};
            div_r   <= divisor;
            cnt     <= CW'(WIDTH - 1);
            running <= 1'b1;
         end else if (running) begin
            rem   <= next_rem[WIDTH-1:0];
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            cnt   <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               running  <= 1'b0;
               rem_done <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/prime_checker_seq.sv
// ============================================================================
// prime_checker_seq : multi-cycle 6k+-1 trial-division prime tester
// Revision          : 1.0
// ============================================================================
`default_nettype none

module prime_checker_seq
   import prime_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int FACTOR_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_num,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_prime,
   output logic [WIDTH-1:0] out_factor,
   output logic             busy
);

   state_t state, state_nx;

   logic [WIDTH-1:0]   n;
   logic [WIDTH-1:0]   d;
   logic               phase;
   logic               prime_r;
   logic [WIDTH-1:0]   factor_r;

   logic               n_small;
   logic               n_two_three;
   logic               n_even_comp;
   logic [2*WIDTH-1:0] d_sq;
   logic               sq_gt;
   logic               rem_start;
   logic               rem_done;
   logic [WIDTH-1:0]   rem;

   assign n_small     = (n <= WIDTH'(1));
   assign n_two_three = (n == WIDTH'(2)) | (n == WIDTH'(3));
   assign n_even_comp = ~n[0] & ~n_small & ~n_two_three;
   assign d_sq        = (2*WIDTH)'(d) * (2*WIDTH)'(d);
   assign sq_gt       = d_sq > (2*WIDTH)'(n);
   assign rem_start   = (state == CHECK) & ~sq_gt;

   prime_rem_unit #(.WIDTH(WIDTH)) u_rem (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (rem_start),
      .dividend (n),
      .divisor  (d),
      .rem_done (rem_done),
      .rem      (rem)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (in_valid) state_nx = CLASSIFY;
         CLASSIFY: state_nx = (n_small | n_two_three | n_even_comp) ? RESULT : CHECK;
         CHECK:    state_nx = sq_gt ? RESULT : WAIT;
         WAIT:     if (rem_done) state_nx = (rem == '0) ? RESULT : CHECK;
         RESULT:   if (out_ready) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready   = (state == IDLE);
      busy       = (state != IDLE);
      out_valid  = (state == RESULT);
      out_prime  = prime_r;
      out_factor = (FACTOR_EN != 0) ? factor_r : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n        <= '0;
         d        <= '0;
         phase    <= 1'b0;
         prime_r  <= 1'b0;
         factor_r <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) n <= in_num;
            CLASSIFY: begin
               d        <= WIDTH'(FIRST_ODD_DIV);
               phase    <= 1'b0;
               prime_r  <= n_two_three;
               factor_r <= n_even_comp ? WIDTH'(2) : '0;
            end
            CHECK: if (sq_gt) begin
               prime_r  <= 1'b1;
               factor_r <= '0;
            end
            WAIT: if (rem_done) begin
               if (rem == '0) begin
                  prime_r  <= 1'b0;
                  factor_r <= d;
               end else begin
                  d <= d + WIDTH'(div_step(phase));
                  // 3->5 and 5->7 are both +2, so the phase only starts toggling after 3.
                  if (d != WIDTH'(FIRST_ODD_DIV)) phase <= ~phase;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_prime_checker_seq.sv
// ============================================================================
// tb_prime_checker_seq : directed self-checking bench, WIDTH=16
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_prime_checker_seq;

   localparam int W     = 16;
   localparam int LIMIT = 2000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_num;
   logic          out_valid;
   logic          out_ready;
   logic          out_prime;
   logic [W-1:0]  out_factor;
   logic          busy;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   prime_checker_seq #(.WIDTH(W), .FACTOR_EN(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_num     (in_num),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_prime  (out_prime),
      .out_factor (out_factor),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept num, count cycles to out_valid, check result, then complete handshake.
   task automatic run_num(input logic [W-1:0] num, input logic exp_prime,
                          input logic [W-1:0] exp_factor, input int exp_lat);
      int c;
      check("idle_ready", in_ready, 1);
      in_valid = 1'b1;
      in_num   = num;
      tick();
      in_valid = 1'b0;
      in_num   = ~num;
      c = 1;
      check("busy_after_accept", busy, 1);
      check("ready_low_busy", in_ready, 0);
      while (!out_valid && c < LIMIT) begin
         tick();
         c++;
      end
      check("latency", c, exp_lat);
      check("prime", out_prime, exp_prime);
      check("factor", out_factor, exp_factor);
      tick();
      check("valid_drop", out_valid, 0);
   endtask

   initial begin
      int c;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_num    = '0;
      out_ready = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_prime", out_prime, 0);
      check("rst_factor", out_factor, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Trivial, even and small-composite numbers
      run_num(16'd0, 1'b0, 16'd0, 2);
      run_num(16'd1, 1'b0, 16'd0, 2);
      run_num(16'd2, 1'b1, 16'd0, 2);
      run_num(16'd3, 1'b1, 16'd0, 2);
      run_num(16'd4, 1'b0, 16'd2, 2);
      run_num(16'd9, 1'b0, 16'd3, 19);
      // Square boundaries
      run_num(16'd25, 1'b0, 16'd5, 36);
      run_num(16'd49, 1'b0, 16'd7, 53);
      // Primes and the all-ones word
      run_num(16'd97, 1'b1, 16'd0, 54);
      run_num(16'd65521, 1'b1, 16'd0, 1448);
      run_num(16'd65535, 1'b0, 16'd3, 19);

      // Backpressure on 91 with 13 waiting at the input
      out_ready = 1'b0;
      check("bp_idle_ready", in_ready, 1);
      in_valid = 1'b1;
      in_num   = 16'd91;
      tick();
      in_num = 16'd13;
      c = 1;
      while (!out_valid && c < LIMIT) begin
         tick();
         c++;
      end
      check("bp_latency", c, 53);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid_hold", out_valid, 1);
         check("bp_prime_hold", out_prime, 0);
         check("bp_factor_hold", out_factor, 7);
         check("bp_ready_low", in_ready, 0);
         tick();
      end
      out_ready = 1'b1;
      check("bp_valid_last", out_valid, 1);
      tick();
      check("bp_after_hs_valid", out_valid, 0);
      check("bp_after_hs_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      c = 1;
      check("bp13_busy", busy, 1);
      while (!out_valid && c < LIMIT) begin
         tick();
         c++;
      end
      check("bp13_latency", c, 20);
      check("bp13_prime", out_prime, 1);
      check("bp13_factor", out_factor, 0);
      tick();

      // Reset in the middle of a long test
      check("mr_idle_ready", in_ready, 1);
      in_valid = 1'b1;
      in_num   = 16'd65521;
      tick();
      in_valid = 1'b0;
      repeat (40) tick();
      check("mr_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mr_in_ready", in_ready, 1);
      check("mr_out_valid", out_valid, 0);
      check("mr_busy", busy, 0);
      check("mr_prime", out_prime, 0);
      check("mr_factor", out_factor, 0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mr_no_result", out_valid, 0);
      end
      run_num(16'd13, 1'b1, 16'd0, 20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
